// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS memory-access pipeline stage.
// Accepts one ALU result at a time, performs an optional data-memory
// load/store with alignment checking, lane steering and timeout abort,
// then presents a writeback record until the consumer takes it.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  // upstream (ALU)
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [31:0] ALU_result,
  input  logic [31:0] rt_reg,
  input  logic [4:0]  dest_reg,
  // data memory
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  // writeback and status
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        mem_timeout
);

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        state;
  logic [5:0]    op_q;
  logic [1:0]    addr_lo_q;
  logic [4:0]    dest_q;
  logic [CW-1:0] cnt;

  logic          in_load;
  logic          in_store;
  logic          in_aligned;
  logic [3:0]    in_be;
  logic [31:0]   in_wdata;
  logic          in_wb_en;
  logic [31:0]   load_data;
  logic          q_load;

  // Decode the incoming instruction: class, alignment, lanes, store data, writeback enable
  always_comb begin
    in_load    = 1'b0;
    in_store   = 1'b0;
    in_aligned = 1'b1;
    in_be      = 4'b1111;
    in_wdata   = '0;
    in_wb_en   = 1'b0;
    case (opcode)
      OP_LB: begin
        in_load = 1'b1;
        in_be   = 4'b0001 << ALU_result[1:0];
      end
      OP_LH: begin
        in_load    = 1'b1;
        in_aligned = ~ALU_result[0];
        in_be      = ALU_result[1] ? 4'b1100 : 4'b0011;
      end
      OP_LW: begin
        in_load    = 1'b1;
        in_aligned = (ALU_result[1:0] == 2'b00);
      end
      OP_SB: begin
        in_store = 1'b1;
        in_be    = 4'b0001 << ALU_result[1:0];
        in_wdata = {4{rt_reg[7:0]}};
      end
      OP_SH: begin
        in_store   = 1'b1;
        in_aligned = ~ALU_result[0];
        in_be      = ALU_result[1] ? 4'b1100 : 4'b0011;
        in_wdata   = {2{rt_reg[15:0]}};
      end
      OP_SW: begin
        in_store   = 1'b1;
        in_aligned = (ALU_result[1:0] == 2'b00);
        in_wdata   = rt_reg;
      end
      OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: in_wb_en = 1'b1;
      default: in_wb_en = 1'b0;
    endcase
  end

  // Pick and sign-extend the addressed lane of the returned read data
  always_comb begin
    q_load    = (op_q == OP_LB) || (op_q == OP_LH) || (op_q == OP_LW);
    load_data = mem_rdata;
    case (op_q)
      OP_LB: begin
        case (addr_lo_q)
          2'd0:    load_data = {{24{mem_rdata[7]}},  mem_rdata[7:0]};
          2'd1:    load_data = {{24{mem_rdata[15]}}, mem_rdata[15:8]};
          2'd2:    load_data = {{24{mem_rdata[23]}}, mem_rdata[23:16]};
          default: load_data = {{24{mem_rdata[31]}}, mem_rdata[31:24]};
        endcase
      end
      OP_LH: begin
        if (addr_lo_q[1]) load_data = {{16{mem_rdata[31]}}, mem_rdata[31:16]};
        else              load_data = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      end
      default: load_data = mem_rdata;
    endcase
  end

  // Stage FSM with registered handshake, memory and writeback outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      op_q        <= '0;
      addr_lo_q   <= '0;
      dest_q      <= '0;
      cnt         <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
      wb_valid    <= 1'b0;
      wb_en       <= 1'b0;
      wb_reg      <= '0;
      wb_data     <= '0;
      misalign    <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      misalign    <= 1'b0;
      mem_timeout <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready  <= 1'b0;
            op_q      <= opcode;
            addr_lo_q <= ALU_result[1:0];
            dest_q    <= dest_reg;
            if (in_load || in_store) begin
              if (in_aligned) begin
                state     <= ACCESS;
                cnt       <= '0;
                mem_req   <= 1'b1;
                mem_we    <= in_store;
                mem_addr  <= {ALU_result[31:2], 2'b00};
                mem_be    <= in_be;
                mem_wdata <= in_wdata;
              end else begin
                state    <= RESP;
                misalign <= 1'b1;
                wb_valid <= 1'b1;
                wb_en    <= 1'b0;
                wb_reg   <= dest_reg;
                wb_data  <= '0;
              end
            end else begin
              state    <= RESP;
              wb_valid <= 1'b1;
              wb_en    <= in_wb_en;
              wb_reg   <= dest_reg;
              wb_data  <= ALU_result;
            end
          end
        end
        ACCESS: begin
          if (mem_ack || (cnt == CW'(TIMEOUT - 1))) begin
            // ack wins over timeout when both land on the last allowed cycle
            state     <= RESP;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b1;
            wb_reg    <= dest_q;
            if (mem_ack) begin
              wb_en   <= q_load;
              wb_data <= q_load ? load_data : '0;
            end else begin
              mem_timeout <= 1'b1;
              wb_en       <= 1'b0;
              wb_data     <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          if (wb_ready) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            wb_valid <= 1'b0;
            wb_en    <= 1'b0;
            wb_reg   <= '0;
            wb_data  <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed, table-driven bench for mem_access_stage.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [31:0] ALU_result;
  logic [31:0] rt_reg;
  logic [4:0]  dest_reg;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        misalign;
  logic        mem_timeout;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .ALU_result (ALU_result),
    .rt_reg     (rt_reg),
    .dest_reg   (dest_reg),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_en      (wb_en),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .misalign   (misalign),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic        exp_en;
  } alu_vec_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [31:0] rdata;
    int unsigned delay;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_wb_en;
    logic [31:0] exp_wb_data;
  } mem_vec_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
  } mis_vec_t;

  alu_vec_t alu_tbl[11];
  mem_vec_t mem_tbl[10];
  mis_vec_t mis_tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Wait (bounded) for in_ready at a falling edge, then present one instruction for one accept edge
  task automatic issue(input logic [5:0] op, input logic [31:0] alu,
                       input logic [31:0] rt, input logic [4:0] dest);
    @(negedge clk);
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    chk("issue_in_ready", {31'b0, in_ready}, 32'd1);
    opcode     = op;
    ALU_result = alu;
    rt_reg     = rt;
    dest_reg   = dest;
    in_valid   = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Consume the writeback record and confirm the stage is ready again
  task automatic retire();
    @(negedge clk);
    wb_ready = 1'b1;
    @(posedge clk);
    #1 wb_ready = 1'b0;
    @(negedge clk);
    chk("retire_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("retire_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int unsigned req_cycles;

    alu_tbl[0]  = '{6'b000000, 32'h0000_0007,  5'd5,  1'b1};
    alu_tbl[1]  = '{6'b001000, 32'h1234_5678,  5'd31, 1'b1};
    alu_tbl[2]  = '{6'b001100, 32'h0000_00F0,  5'd1,  1'b1};
    alu_tbl[3]  = '{6'b001101, 32'hFFFF_0000,  5'd2,  1'b1};
    alu_tbl[4]  = '{6'b001010, 32'h0000_0001,  5'd3,  1'b1};
    alu_tbl[5]  = '{6'b001111, 32'hABCD_0000,  5'd4,  1'b1};
    alu_tbl[6]  = '{6'b000100, 32'h0000_0040,  5'd6,  1'b0};
    alu_tbl[7]  = '{6'b000101, 32'h0000_0044,  5'd7,  1'b0};
    alu_tbl[8]  = '{6'b000001, 32'h0000_0048,  5'd8,  1'b0};
    alu_tbl[9]  = '{6'b000010, 32'h0000_1000,  5'd9,  1'b0};
    alu_tbl[10] = '{6'b100100, 32'h0000_0103,  5'd10, 1'b0};

    mem_tbl[0] = '{6'b100000, 32'h0000_0102, 32'h0, 32'h0080_0000, 3, 1'b0, 4'b0100, 32'h0000_0100, 32'h0,         1'b1, 32'hFFFF_FF80};
    mem_tbl[1] = '{6'b101001, 32'h0000_0012, 32'h0000_BEEF, 32'h0, 1, 1'b1, 4'b1100, 32'h0000_0010, 32'hBEEF_BEEF, 1'b0, 32'h0};
    mem_tbl[2] = '{6'b100000, 32'h0000_0003, 32'h0, 32'h7F00_0000, 0, 1'b0, 4'b1000, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_007F};
    mem_tbl[3] = '{6'b100000, 32'h0000_0000, 32'h0, 32'h0000_00FF, 2, 1'b0, 4'b0001, 32'h0000_0000, 32'h0,         1'b1, 32'hFFFF_FFFF};
    mem_tbl[4] = '{6'b100001, 32'h0000_0022, 32'h0, 32'h8001_1234, 1, 1'b0, 4'b1100, 32'h0000_0020, 32'h0,         1'b1, 32'hFFFF_8001};
    mem_tbl[5] = '{6'b100001, 32'h0000_0020, 32'h0, 32'h8001_1234, 0, 1'b0, 4'b0011, 32'h0000_0020, 32'h0,         1'b1, 32'h0000_1234};
    mem_tbl[6] = '{6'b100011, 32'h0000_0044, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 4'b1111, 32'h0000_0044, 32'h0,         1'b1, 32'hDEAD_BEEF};
    mem_tbl[7] = '{6'b101000, 32'h0000_0001, 32'h1234_5678, 32'h0, 2, 1'b1, 4'b0010, 32'h0000_0000, 32'h7878_7878, 1'b0, 32'h0};
    mem_tbl[8] = '{6'b101011, 32'h0000_0008, 32'hCAFE_F00D, 32'h0, 5, 1'b1, 4'b1111, 32'h0000_0008, 32'hCAFE_F00D, 1'b0, 32'h0};
    mem_tbl[9] = '{6'b101001, 32'h0000_0010, 32'hAAAA_5555, 32'h0, 15, 1'b1, 4'b0011, 32'h0000_0010, 32'h5555_5555, 1'b0, 32'h0};

    mis_tbl[0] = '{6'b100011, 32'h0000_0006};
    mis_tbl[1] = '{6'b100001, 32'h0000_0101};
    mis_tbl[2] = '{6'b101001, 32'h0000_0103};
    mis_tbl[3] = '{6'b101011, 32'h0000_0002};
    mis_tbl[4] = '{6'b100011, 32'h0000_0005};

    reset_n    = 1'b0;
    in_valid   = 1'b0;
    opcode     = '0;
    ALU_result = '0;
    rt_reg     = '0;
    dest_reg   = '0;
    mem_rdata  = '0;
    mem_ack    = 1'b0;
    wb_ready   = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_ctrl", {25'b0, mem_req, mem_we, wb_valid, wb_en, misalign, mem_timeout, 1'b0}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Non-memory opcodes
    foreach (alu_tbl[i]) begin
      issue(alu_tbl[i].op, alu_tbl[i].alu, 32'h5A5A_5A5A, alu_tbl[i].dest);
      @(negedge clk);
      chk("alu_wb_valid", {31'b0, wb_valid}, 32'd1);
      chk("alu_wb_en", {31'b0, wb_en}, {31'b0, alu_tbl[i].exp_en});
      chk("alu_wb_reg", {27'b0, wb_reg}, {27'b0, alu_tbl[i].dest});
      chk("alu_wb_data", wb_data, alu_tbl[i].alu);
      chk("alu_no_req", {31'b0, mem_req}, 32'd0);
      chk("alu_in_ready", {31'b0, in_ready}, 32'd0);
      if (i == 0) begin
        @(negedge clk);
        chk("alu_hold_valid", {31'b0, wb_valid}, 32'd1);
        chk("alu_hold_data", wb_data, alu_tbl[i].alu);
      end
      retire();
    end

    // Aligned memory accesses
    foreach (mem_tbl[i]) begin
      issue(mem_tbl[i].op, mem_tbl[i].addr, mem_tbl[i].rt, 5'(i + 11));
      @(negedge clk);
      chk("mem_req_on", {31'b0, mem_req}, 32'd1);
      chk("mem_we", {31'b0, mem_we}, {31'b0, mem_tbl[i].exp_we});
      chk("mem_be", {28'b0, mem_be}, {28'b0, mem_tbl[i].exp_be});
      chk("mem_addr", mem_addr, mem_tbl[i].exp_addr);
      if (mem_tbl[i].exp_we) chk("mem_wdata", mem_wdata, mem_tbl[i].exp_wdata);
      mem_rdata = 32'hA5A5_A5A5;
      repeat (mem_tbl[i].delay) @(negedge clk);
      chk("mem_req_held", {31'b0, mem_req}, 32'd1);
      chk("mem_addr_held", mem_addr, mem_tbl[i].exp_addr);
      mem_ack   = 1'b1;
      mem_rdata = mem_tbl[i].rdata;
      @(posedge clk);
      #1 mem_ack = 1'b0;
      mem_rdata  = 32'h0;
      @(negedge clk);
      chk("mem_req_off", {31'b0, mem_req}, 32'd0);
      chk("mem_wb_valid", {31'b0, wb_valid}, 32'd1);
      chk("mem_wb_en", {31'b0, wb_en}, {31'b0, mem_tbl[i].exp_wb_en});
      chk("mem_wb_reg", {27'b0, wb_reg}, 32'(i + 11));
      if (mem_tbl[i].exp_wb_en) chk("mem_wb_data", wb_data, mem_tbl[i].exp_wb_data);
      retire();
    end

    // Misaligned accesses
    foreach (mis_tbl[i]) begin
      issue(mis_tbl[i].op, mis_tbl[i].addr, 32'h1111_2222, 5'd20);
      @(negedge clk);
      chk("mis_pulse", {31'b0, misalign}, 32'd1);
      chk("mis_no_req", {31'b0, mem_req}, 32'd0);
      chk("mis_wb_valid", {31'b0, wb_valid}, 32'd1);
      chk("mis_wb_en", {31'b0, wb_en}, 32'd0);
      @(negedge clk);
      chk("mis_pulse_end", {31'b0, misalign}, 32'd0);
      chk("mis_still_no_req", {31'b0, mem_req}, 32'd0);
      retire();
    end

    // Timeout: sw never acknowledged
    issue(6'b101011, 32'h0000_0080, 32'h0BAD_F00D, 5'd21);
    req_cycles = 0;
    @(negedge clk);
    for (int i = 0; i < 40 && mem_req; i++) begin
      req_cycles++;
      @(negedge clk);
    end
    chk("to_req_cycles", req_cycles, 32'd16);
    chk("to_pulse", {31'b0, mem_timeout}, 32'd1);
    chk("to_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("to_wb_en", {31'b0, wb_en}, 32'd0);
    @(negedge clk);
    chk("to_pulse_end", {31'b0, mem_timeout}, 32'd0);
    retire();

    // Reset during ACCESS, then a stale ack
    issue(6'b100011, 32'h0000_0040, 32'h0, 5'd22);
    @(negedge clk);
    chk("ra_req_before", {31'b0, mem_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("ra_ctrl", {24'b0, in_ready, mem_req, mem_we, wb_valid, wb_en, misalign, mem_timeout, 1'b0}, 32'd0);
    chk("ra_addr", mem_addr, 32'd0);
    chk("ra_be_reg", {23'b0, mem_be, wb_reg}, 32'd0);
    chk("ra_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    repeat (3) begin
      @(negedge clk);
      chk("ra_stale_wb_valid", {31'b0, wb_valid}, 32'd0);
      chk("ra_stale_req", {31'b0, mem_req}, 32'd0);
    end
    chk("ra_in_ready", {31'b0, in_ready}, 32'd1);
    mem_ack = 1'b0;

    // Reset during RESP
    issue(6'b000000, 32'h0000_0099, 32'h0, 5'd23);
    @(negedge clk);
    chk("rr_wb_valid_before", {31'b0, wb_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rr_wb_cleared", {30'b0, wb_valid, wb_en}, 32'd0);
    chk("rr_wb_data", wb_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rr_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rr_no_wb_valid", {31'b0, wb_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
